// File: rtl/mole_pattern_gen_if.sv
// Request/response bundle between the round controller and mole_pattern_gen.
//
// The master side is the round controller plus the display/scoring consumer.
// It drives req, num_moles and out_ready. The slave side is the pattern
// generator. It drives busy, out_valid and moles_out.
//
//   req        master->slave  request a new pattern (sampled only when idle)
//   num_moles  master->slave  number of moles wanted, sampled with req
//   out_ready  master->slave  consumer accepts the offered pattern
//   busy       slave->master  generator is drawing or holding a pattern
//   out_valid  slave->master  moles_out holds a complete pattern
//   moles_out  slave->master  bit i set = mole in hole i
interface mole_pattern_gen_if #(
  parameter int NUM_HOLES = 5,
  parameter int MAX_MOLES = 3
);
  localparam int CW = $clog2(MAX_MOLES + 1);

  logic                 req;
  logic [CW-1:0]        num_moles;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_HOLES-1:0] moles_out;

  modport master (
    output req,
    output num_moles,
    output out_ready,
    input  busy,
    input  out_valid,
    input  moles_out
  );

  modport slave (
    input  req,
    input  num_moles,
    input  out_ready,
    output busy,
    output out_valid,
    output moles_out
  );
endinterface

// File: rtl/mole_pattern_gen.sv
// mole_pattern_gen: pseudo-random mole spawner.
//
// On request, the block picks n distinct holes out of NUM_HOLES. Here
// n = min(num_moles, MAX_MOLES). It draws one candidate hole per cycle from
// a free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1). A candidate is
// rejected when it is out of range, already taken, or excluded. After
// MAX_TRIES-1 straight rejections the lowest free hole is taken instead, so
// a pattern never needs more than n*MAX_TRIES cycles. The finished pattern is
// held on a valid/ready handshake until the consumer takes it.
//
// Ports:
//   clock  system clock, all state on the rising edge
//   reset  asynchronous, active-high; returns everything (LFSR included) to reset values
//   bus    mole_pattern_gen_if slave modport (req, num_moles, out_ready in;
//          busy, out_valid, moles_out out)
//
// Optional feature, enabled by defining MOLE_NO_REPEAT_EN:
//   The last handed-over pattern is remembered. Its holes are excluded from
//   the next request unless too few holes would remain free to satisfy it.
module mole_pattern_gen #(
  parameter int                NUM_HOLES = 5,
  parameter int                MAX_MOLES = 3,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                MAX_TRIES = 8
) (
  input logic              clock,
  input logic              reset,
  mole_pattern_gen_if.slave bus
);

  localparam int                IW        = $clog2(NUM_HOLES);
  localparam int                CW        = $clog2(MAX_MOLES + 1);
  localparam int                TW        = $clog2(MAX_TRIES + 1);
  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               r_state;
  logic [LFSR_W-1:0]    r_lfsr;
  logic [NUM_HOLES-1:0] r_mask;
  logic [NUM_HOLES-1:0] r_moles;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_target;
  logic [TW-1:0]        r_tries;
  logic                 r_valid;
  logic                 r_busy;

  logic [LFSR_W-1:0]    w_lfsrNext;
  logic [IW-1:0]        w_idx;
  logic [NUM_HOLES-1:0] w_randBit;
  logic [NUM_HOLES-1:0] w_blocked;
  logic [NUM_HOLES-1:0] w_fallBit;
  logic [NUM_HOLES-1:0] w_pickBit;
  logic [NUM_HOLES-1:0] w_reqExcl;
  logic [CW-1:0]        w_reqN;
  logic                 w_randOk;
  logic                 w_accept;
  logic                 w_lastPick;

`ifdef MOLE_NO_REPEAT_EN
  logic [NUM_HOLES-1:0] r_prev;
  logic [NUM_HOLES-1:0] r_excl;

  // Exclude the previous pattern only when enough holes remain outside it
  // for this request; otherwise the request could never complete.
  always_comb begin
    w_reqExcl = '0;
    if (32'(w_reqN) <= 32'(NUM_HOLES - $countones(r_prev)))
      w_reqExcl = r_prev;
  end

  assign w_blocked = r_mask | r_excl;
`else
  assign w_reqExcl = '0;
  assign w_blocked = r_mask;
`endif

  // Right-shifting Galois step. A nonzero state never reaches zero.
  assign w_lfsrNext = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);

  // The draw index uses the current LFSR value, before this cycle's advance.
  assign w_idx = r_lfsr[IW-1:0];

  // Decode the index one-hot. Indices at or above NUM_HOLES give an empty
  // vector, which counts as a rejection.
  always_comb begin
    w_randBit = '0;
    for (int i = 0; i < NUM_HOLES; i++)
      w_randBit[i] = (w_idx == IW'(i));
  end

  assign w_randOk = (|w_randBit) && ((w_randBit & w_blocked) == '0);

  // Lowest clear bit of the blocked vector: ~b & (b+1).
  assign w_fallBit = ~w_blocked & (w_blocked + NUM_HOLES'(1));

  assign w_accept   = w_randOk || (r_tries == TW'(MAX_TRIES - 1));
  assign w_pickBit  = w_randOk ? w_randBit : w_fallBit;
  assign w_lastPick = ((r_cnt + CW'(1)) == r_target);

  assign w_reqN = (bus.num_moles > CW'(MAX_MOLES)) ? CW'(MAX_MOLES) : bus.num_moles;

  // Single state machine. The LFSR free-runs in every state. busy, out_valid
  // and moles_out are registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_lfsr   <= SEED;
      r_mask   <= '0;
      r_moles  <= '0;
      r_cnt    <= '0;
      r_target <= '0;
      r_tries  <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
`ifdef MOLE_NO_REPEAT_EN
      r_prev   <= '0;
      r_excl   <= '0;
`endif
    end else begin
      r_lfsr <= w_lfsrNext;
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_mask   <= '0;
            r_cnt    <= '0;
            r_tries  <= '0;
            r_target <= w_reqN;
            r_busy   <= 1'b1;
`ifdef MOLE_NO_REPEAT_EN
            r_excl   <= w_reqExcl;
`endif
            if (w_reqN == '0) begin
              r_moles <= '0;
              r_valid <= 1'b1;
              r_state <= HOLD;
            end else begin
              r_state <= DRAW;
            end
          end
        end
        DRAW: begin
          if (w_accept) begin
            r_mask  <= r_mask | w_pickBit;
            r_cnt   <= r_cnt + CW'(1);
            r_tries <= '0;
            if (w_lastPick) begin
              r_moles <= r_mask | w_pickBit;
              r_valid <= 1'b1;
              r_state <= HOLD;
            end
          end else begin
            r_tries <= r_tries + TW'(1);
          end
        end
        HOLD: begin
          if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
`ifdef MOLE_NO_REPEAT_EN
            r_prev  <= r_moles;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef MOLE_NO_REPEAT_EN
  // Keeps the unused exclusion vector visibly consumed in the default build.
  logic w_unusedExcl;
  assign w_unusedExcl = |w_reqExcl;
`endif

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_valid;
  assign bus.moles_out = r_moles;

endmodule

// File: tb/tb_mole_pattern_gen.sv
// Testbench for mole_pattern_gen.
//
// The reference model predicts each pattern and its completion cycle from
// the drawing rules. It steps a private copy of the LFSR sequence and replays
// the rejection-sampling draws with plain arithmetic. A fixed table of
// requests and a randomized run are both checked against that model. Short
// hand-written sequences cover the corner cases: request together with
// handshake, reset in mid-draw, and the no-repeat option when it is compiled in.
module tb_mole_pattern_gen;

  localparam int          NUM_HOLES     = 5;
  localparam int          MAX_MOLES     = 3;
  localparam int          MAX_TRIES     = 8;
  localparam logic [15:0] SEED          = 16'hACE1;
  localparam int          CW            = $clog2(MAX_MOLES + 1);
  localparam int          IDX_RANGE     = 1 << $clog2(NUM_HOLES);
  localparam int          LATENCY_BOUND = MAX_MOLES * MAX_TRIES + 4;

`ifdef MOLE_NO_REPEAT_EN
  localparam bit NoRepeat = 1'b1;
`else
  localparam bit NoRepeat = 1'b0;
`endif

  typedef struct {
    int numMoles;
    int readyDelay;
    int expPop;
    bit pulseReq;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mole_pattern_gen_if #(.NUM_HOLES(NUM_HOLES), .MAX_MOLES(MAX_MOLES)) bus ();

  mole_pattern_gen #(
    .NUM_HOLES(NUM_HOLES),
    .MAX_MOLES(MAX_MOLES),
    .LFSR_W   (16),
    .SEED     (SEED),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0]          modelLfsr;
  logic [NUM_HOLES-1:0] modelPrev = '0;
  logic [NUM_HOLES-1:0] pat, firstPat, lastPat;
  vec_t                 vecs[9];

  // One step of the LFSR sequence for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // The model's LFSR copy follows the DUT's value, edge by edge.
  always @(posedge clock or posedge reset)
    if (reset) modelLfsr <= SEED;
    else       modelLfsr <= lfsrStep(modelLfsr);

  // Holes excluded for a request of n moles, given the last handed-over pattern.
  function automatic logic [NUM_HOLES-1:0] exclFor(input int n);
    if (NoRepeat && (n <= NUM_HOLES - $countones(modelPrev)))
      return modelPrev;
    return '0;
  endfunction

  // Replay the draws for one request. startLfsr is the LFSR value at the first draw.
  function automatic void predict(input logic [15:0] startLfsr, input int n,
                                  input logic [NUM_HOLES-1:0] excl,
                                  output logic [NUM_HOLES-1:0] pattern, output int cycles);
    logic [15:0] l = startLfsr;
    int got = 0;
    int tries = 0;
    pattern = '0;
    cycles = 0;
    while (got < n) begin
      int idx = int'(l) % IDX_RANGE;
      cycles++;
      if (idx < NUM_HOLES && !pattern[idx] && !excl[idx]) begin
        pattern[idx] = 1'b1;
        got++;
        tries = 0;
      end else if (tries == MAX_TRIES - 1) begin
        bit found = 1'b0;
        for (int h = 0; h < NUM_HOLES; h++)
          if (!found && !pattern[h] && !excl[h]) begin
            pattern[h] = 1'b1;
            found = 1'b1;
          end
        got++;
        tries = 0;
      end else begin
        tries++;
      end
      l = lfsrStep(l);
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Issue a request from a falling edge and wait for the pattern.
  // Checks the latency and the pattern against the model.
  task automatic applyStimulus(input int numMoles, output logic [NUM_HOLES-1:0] expPat);
    int n;
    int expCycles;
    int waited;
    n = (numMoles > MAX_MOLES) ? MAX_MOLES : numMoles;
    expPat = '0;
    expCycles = 0;
    if (n > 0) predict(lfsrStep(modelLfsr), n, exclFor(n), expPat, expCycles);
    bus.req = 1'b1;
    bus.num_moles = CW'(numMoles);
    @(negedge clock);
    bus.req = 1'b0;
    checkOutput("busyAfterReq", int'(bus.busy), 1);
    waited = 0;
    while (!bus.out_valid && waited < LATENCY_BOUND) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("outValid", int'(bus.out_valid), 1);
    checkOutput("latency", waited, expCycles);
    checkOutput("pattern", int'(bus.moles_out), int'(expPat));
  endtask

  // Hold the pattern for readyDelay cycles, optionally pulsing req, then
  // complete the handshake. req can also be raised in the handshake cycle.
  task automatic releasePattern(input int readyDelay, input bit pulseReq, input bit reqWithAck,
                                input logic [NUM_HOLES-1:0] expPat);
    for (int i = 0; i < readyDelay; i++) begin
      bus.req = pulseReq && (i % 2 == 0);
      bus.num_moles = CW'($urandom_range(0, MAX_MOLES));
      @(negedge clock);
      checkOutput("holdValid", int'(bus.out_valid), 1);
      checkOutput("holdPattern", int'(bus.moles_out), int'(expPat));
      checkOutput("holdBusy", int'(bus.busy), 1);
    end
    bus.req = reqWithAck;
    bus.num_moles = CW'(1);
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    bus.req = 1'b0;
    modelPrev = expPat;
    checkOutput("ackValid", int'(bus.out_valid), 0);
    checkOutput("ackBusy", int'(bus.busy), 0);
    checkOutput("keepPattern", int'(bus.moles_out), int'(expPat));
  endtask

  initial begin
    bus.req = 1'b0;
    bus.num_moles = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{numMoles: 1, readyDelay: 0,  expPop: 1, pulseReq: 1'b0};
    vecs[1] = '{numMoles: 1, readyDelay: 3,  expPop: 1, pulseReq: 1'b0};
    vecs[2] = '{numMoles: 2, readyDelay: 0,  expPop: 2, pulseReq: 1'b0};
    vecs[3] = '{numMoles: 3, readyDelay: 0,  expPop: 3, pulseReq: 1'b0};
    vecs[4] = '{numMoles: 0, readyDelay: 0,  expPop: 0, pulseReq: 1'b0};
    vecs[5] = '{numMoles: 0, readyDelay: 2,  expPop: 0, pulseReq: 1'b1};
    vecs[6] = '{numMoles: 3, readyDelay: 20, expPop: 3, pulseReq: 1'b1};
    vecs[7] = '{numMoles: 2, readyDelay: 1,  expPop: 2, pulseReq: 1'b0};
    vecs[8] = '{numMoles: 3, readyDelay: 5,  expPop: 3, pulseReq: 1'b1};

    // Reset state.
    repeat (3) @(negedge clock);
    checkOutput("resetBusy", int'(bus.busy), 0);
    checkOutput("resetValid", int'(bus.out_valid), 0);
    checkOutput("resetPattern", int'(bus.moles_out), 0);

    // First request straight after reset. It is kept for the reproduction check.
    reset = 1'b0;
    @(negedge clock);
    applyStimulus(1, firstPat);
    checkOutput("firstOneHot", $countones(bus.moles_out), 1);
    releasePattern(2, 1'b0, 1'b0, firstPat);

    // Table-driven requests.
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].numMoles, pat);
      checkOutput("popcount", $countones(bus.moles_out), vecs[v].expPop);
      releasePattern(vecs[v].readyDelay, vecs[v].pulseReq, 1'b0, pat);
    end

    // A request in the same cycle as the handshake is dropped.
    applyStimulus(2, pat);
    releasePattern(0, 1'b0, 1'b1, pat);
    @(negedge clock);
    checkOutput("reqWithAckIgnored", int'(bus.busy), 0);

    // Randomized requests against the model.
    for (int r = 0; r < 1000; r++) begin
      int k;
      k = (r % 2 == 0) ? MAX_MOLES : int'($urandom_range(0, MAX_MOLES));
      applyStimulus(k, pat);
      checkOutput("randPopcount", $countones(bus.moles_out), k);
      releasePattern(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b0, pat);
    end

`ifdef MOLE_NO_REPEAT_EN
    // Single-mole patterns never repeat back to back.
    lastPat = modelPrev;
    for (int r = 0; r < 200; r++) begin
      applyStimulus(1, pat);
      checkOutput("noRepeat", int'(bus.moles_out == lastPat), 0);
      releasePattern(0, 1'b0, 1'b0, pat);
      lastPat = pat;
    end
    // The exclusion is bypassed when it would leave too few free holes.
    applyStimulus(3, pat);
    releasePattern(0, 1'b0, 1'b0, pat);
    applyStimulus(3, pat);
    checkOutput("bypassPopcount", $countones(bus.moles_out), 3);
    releasePattern(0, 1'b0, 1'b0, pat);
`endif

    // Reset in mid-draw, then repeat the post-reset sequence.
    applyStimulus(2, pat);
    releasePattern(0, 1'b0, 1'b0, pat);
    bus.req = 1'b1;
    bus.num_moles = CW'(3);
    @(negedge clock);
    bus.req = 1'b0;
    checkOutput("drawBusy", int'(bus.busy), 1);
    reset = 1'b1;
    #1;
    checkOutput("midResetBusy", int'(bus.busy), 0);
    checkOutput("midResetValid", int'(bus.out_valid), 0);
    checkOutput("midResetPattern", int'(bus.moles_out), 0);
    modelPrev = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    applyStimulus(1, pat);
    checkOutput("reproduce", int'(bus.moles_out), int'(firstPat));
    releasePattern(1, 1'b0, 1'b0, pat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
